// File: rtl/voice_pkg.sv
// Shared definitions for the polyphony voice allocator: voice occupancy
// states, note/octave field widths, request sequencer states and the action
// chosen for a key event.
package voice_pkg;

    localparam int NOTE_W = 4;
    localparam int OCT_W  = 3;

    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_HELD      = 2'd1,
        V_RELEASING = 2'd2
    } voice_state_e;

    typedef enum logic [1:0] {
        REQ_IDLE   = 2'd0,
        REQ_SEARCH = 2'd1,
        REQ_APPLY  = 2'd2
    } req_state_e;

    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_LOAD    = 2'd1,
        ACT_RELEASE = 2'd2,
        ACT_DROP    = 2'd3
    } action_e;

endpackage

// File: rtl/voice_age_tracker.sv
// Age ranking of the voices. Rank 0 is the most recently loaded voice and
// NUM_VOICES-1 the oldest; the ranks always form a permutation of 0..N-1.
// Provides the oldest voice, preferring RELEASING voices over HELD ones,
// with ties going to the lowest index.
module voice_age_tracker
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    input  logic [$clog2(NUM_VOICES)-1:0] load_idx,
    input  logic [NUM_VOICES-1:0]         rel_mask,
    input  logic [NUM_VOICES-1:0]         held_mask,
    output logic                          oldest_valid,
    output logic [$clog2(NUM_VOICES)-1:0] oldest_idx
);

    localparam int IW = $clog2(NUM_VOICES);

    logic [IW-1:0]         rank_q [NUM_VOICES];
    logic [IW-1:0]         rank_d [NUM_VOICES];
    logic [IW-1:0]         load_rank_s;
    logic [IW-1:0]         best_rank_s;
    logic                  found_s;
    logic [NUM_VOICES-1:0] pick_mask_s;

    // Loaded voice becomes youngest; every voice younger than it ages by one
    always_comb begin
        rank_d      = rank_q;
        load_rank_s = rank_q[load_idx];
        if (load_valid) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (IW'(v) == load_idx) begin
                    rank_d[v] = {IW{1'b0}};
                end else if (rank_q[v] < load_rank_s) begin
                    rank_d[v] = rank_q[v] + IW'(1);
                end else begin
                    rank_d[v] = rank_q[v];
                end
            end
        end else begin
            rank_d = rank_q;
        end
    end

    // Rank registers, reset to the voice index
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                rank_q[v] <= IW'(v);
            end
        end else begin
            rank_q <= rank_d;
        end
    end

    // Oldest-voice select over RELEASING voices, or HELD voices if none release
    always_comb begin
        pick_mask_s  = (|rel_mask) ? rel_mask : held_mask;
        oldest_valid = |pick_mask_s;
        oldest_idx   = {IW{1'b0}};
        best_rank_s  = {IW{1'b0}};
        found_s      = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (pick_mask_s[v] && (!found_s || (rank_q[v] > best_rank_s))) begin
                found_s     = 1'b1;
                best_rank_s = rank_q[v];
                oldest_idx  = IW'(v);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: maps key events onto NUM_VOICES voice datapaths.
// Each event runs IDLE -> SEARCH -> APPLY. Key-on retriggers a voice already
// playing the same pitch, else takes the lowest FREE voice, else (when
// VOICE_STEAL_EN is defined) steals the oldest voice, else is dropped.
// Key-off releases the HELD voice with the same pitch.
// Optional feature macro: VOICE_STEAL_EN (voice stealing; ranks only kept then).
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                key_valid,
    output logic                                key_ready,
    input  logic                                key_on,
    input  logic [NOTE_W-1:0]                   key_note,
    input  logic [OCT_W-1:0]                    key_octave,
    input  logic [NUM_VOICES-1:0]               voice_done,
    output logic [NUM_VOICES-1:0]               voice_gate,
    output logic [NUM_VOICES-1:0]               voice_load,
    output logic [NOTE_W*NUM_VOICES-1:0]        voice_note,
    output logic [OCT_W*NUM_VOICES-1:0]         voice_octave,
    output logic                                drop_pulse,
    output logic [$clog2(NUM_VOICES+1)-1:0]     active_count
);

    localparam int IW = $clog2(NUM_VOICES);
    localparam int CW = $clog2(NUM_VOICES + 1);

    req_state_e            state_q, state_d;
    logic                  ev_on_q, ev_on_d;
    logic [NOTE_W-1:0]     ev_note_q, ev_note_d;
    logic [OCT_W-1:0]      ev_oct_q, ev_oct_d;
    action_e               action_q, action_d;
    logic [IW-1:0]         target_q, target_d;

    voice_state_e          vstate_q [NUM_VOICES];
    voice_state_e          vstate_d [NUM_VOICES];
    logic [NOTE_W-1:0]     note_q   [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d   [NUM_VOICES];
    logic [OCT_W-1:0]      oct_q    [NUM_VOICES];
    logic [OCT_W-1:0]      oct_d    [NUM_VOICES];

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] load_q, load_d;
    logic                  drop_q, drop_d;
    logic [CW-1:0]         count_q, count_d;

    logic                  on_hit_s, off_hit_s, free_hit_s;
    logic [IW-1:0]         on_idx_s, off_idx_s, free_idx_s;
    action_e               action_sel_s;
    logic [IW-1:0]         target_sel_s;

    assign key_ready    = (state_q == REQ_IDLE);
    assign voice_gate   = gate_q;
    assign voice_load   = load_q;
    assign drop_pulse   = drop_q;
    assign active_count = count_q;

    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_pack
        assign voice_note[NOTE_W*gv +: NOTE_W] = note_q[gv];
        assign voice_octave[OCT_W*gv +: OCT_W] = oct_q[gv];
    end

`ifdef VOICE_STEAL_EN
    logic [NUM_VOICES-1:0] rel_mask_s, held_mask_s;
    logic                  oldest_valid_s;
    logic [IW-1:0]         oldest_idx_s;

    // Occupancy masks feeding the oldest-voice select
    always_comb begin
        rel_mask_s  = {NUM_VOICES{1'b0}};
        held_mask_s = {NUM_VOICES{1'b0}};
        for (int v = 0; v < NUM_VOICES; v++) begin
            rel_mask_s[v]  = (vstate_q[v] == V_RELEASING);
            held_mask_s[v] = (vstate_q[v] == V_HELD);
        end
    end

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES)
    ) u_age (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (|load_d),
        .load_idx     (target_q),
        .rel_mask     (rel_mask_s),
        .held_mask    (held_mask_s),
        .oldest_valid (oldest_valid_s),
        .oldest_idx   (oldest_idx_s)
    );
`endif

    // Candidate search: pitch match, key-off match and lowest FREE voice
    always_comb begin
        on_hit_s   = 1'b0;
        off_hit_s  = 1'b0;
        free_hit_s = 1'b0;
        on_idx_s   = {IW{1'b0}};
        off_idx_s  = {IW{1'b0}};
        free_idx_s = {IW{1'b0}};
        // Walk downward so the last hit recorded is the lowest index
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            on_idx_s   = ((vstate_q[v] != V_FREE) && (note_q[v] == ev_note_q) &&
                          (oct_q[v] == ev_oct_q)) ? IW'(v) : on_idx_s;
            on_hit_s   = on_hit_s | ((vstate_q[v] != V_FREE) && (note_q[v] == ev_note_q) &&
                          (oct_q[v] == ev_oct_q));
            off_idx_s  = ((vstate_q[v] == V_HELD) && (note_q[v] == ev_note_q) &&
                          (oct_q[v] == ev_oct_q)) ? IW'(v) : off_idx_s;
            off_hit_s  = off_hit_s | ((vstate_q[v] == V_HELD) && (note_q[v] == ev_note_q) &&
                          (oct_q[v] == ev_oct_q));
            free_idx_s = (vstate_q[v] == V_FREE) ? IW'(v) : free_idx_s;
            free_hit_s = free_hit_s | (vstate_q[v] == V_FREE);
        end
    end

    // Action selection in priority order: match, free, steal, drop
    always_comb begin
        action_sel_s = ACT_NONE;
        target_sel_s = {IW{1'b0}};
        if (ev_on_q) begin
            if (on_hit_s) begin
                action_sel_s = ACT_LOAD;
                target_sel_s = on_idx_s;
            end else if (free_hit_s) begin
                action_sel_s = ACT_LOAD;
                target_sel_s = free_idx_s;
            end else begin
`ifdef VOICE_STEAL_EN
                if (oldest_valid_s) begin
                    action_sel_s = ACT_LOAD;
                    target_sel_s = oldest_idx_s;
                end else begin
                    action_sel_s = ACT_DROP;
                end
`else
                action_sel_s = ACT_DROP;
`endif
            end
        end else begin
            if (off_hit_s) begin
                action_sel_s = ACT_RELEASE;
                target_sel_s = off_idx_s;
            end else begin
                action_sel_s = ACT_NONE;
            end
        end
    end

    // Request sequencing plus per-voice state, note and octave updates
    always_comb begin
        state_d   = state_q;
        ev_on_d   = ev_on_q;
        ev_note_d = ev_note_q;
        ev_oct_d  = ev_oct_q;
        action_d  = action_q;
        target_d  = target_q;
        vstate_d  = vstate_q;
        note_d    = note_q;
        oct_d     = oct_q;
        load_d    = {NUM_VOICES{1'b0}};
        drop_d    = 1'b0;

        // Release-complete only frees a voice that is releasing; an APPLY
        // below overrides it for the targeted voice
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_done[v] && (vstate_q[v] == V_RELEASING)) begin
                vstate_d[v] = V_FREE;
            end else begin
                vstate_d[v] = vstate_q[v];
            end
        end

        case (state_q)
            REQ_IDLE: begin
                if (key_valid) begin
                    ev_on_d   = key_on;
                    ev_note_d = key_note;
                    ev_oct_d  = key_octave;
                    state_d   = REQ_SEARCH;
                end else begin
                    state_d = REQ_IDLE;
                end
            end
            REQ_SEARCH: begin
                action_d = action_sel_s;
                target_d = target_sel_s;
                state_d  = REQ_APPLY;
            end
            REQ_APPLY: begin
                state_d = REQ_IDLE;
                case (action_q)
                    ACT_LOAD: begin
                        vstate_d[target_q] = V_HELD;
                        note_d[target_q]   = ev_note_q;
                        oct_d[target_q]    = ev_oct_q;
                        load_d[target_q]   = 1'b1;
                    end
                    ACT_RELEASE: begin
                        vstate_d[target_q] = V_RELEASING;
                    end
                    ACT_DROP: begin
                        drop_d = 1'b1;
                    end
                    default: begin
                        drop_d = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d = REQ_IDLE;
            end
        endcase
    end

    // Gate level and occupancy follow the next voice state
    always_comb begin
        gate_d  = {NUM_VOICES{1'b0}};
        count_d = {CW{1'b0}};
        for (int v = 0; v < NUM_VOICES; v++) begin
            gate_d[v] = (vstate_d[v] == V_HELD);
            count_d   = count_d + ((vstate_d[v] != V_FREE) ? CW'(1) : CW'(0));
        end
    end

    // State and output registers; reset discards any in-flight event
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= REQ_IDLE;
            ev_on_q   <= 1'b0;
            ev_note_q <= {NOTE_W{1'b0}};
            ev_oct_q  <= {OCT_W{1'b0}};
            action_q  <= ACT_NONE;
            target_q  <= {IW{1'b0}};
            for (int v = 0; v < NUM_VOICES; v++) begin
                vstate_q[v] <= V_FREE;
                note_q[v]   <= {NOTE_W{1'b0}};
                oct_q[v]    <= {OCT_W{1'b0}};
            end
            gate_q    <= {NUM_VOICES{1'b0}};
            load_q    <= {NUM_VOICES{1'b0}};
            drop_q    <= 1'b0;
            count_q   <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            ev_on_q   <= ev_on_d;
            ev_note_q <= ev_note_d;
            ev_oct_q  <= ev_oct_d;
            action_q  <= action_d;
            target_q  <= target_d;
            vstate_q  <= vstate_d;
            note_q    <= note_d;
            oct_q     <= oct_d;
            gate_q    <= gate_d;
            load_q    <= load_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphony scheduler that shares a bank of `NUM_VOICES` synth voice datapaths between incoming key events. It sits between the keyboard/note decoder and the per-voice note/envelope/oscillator chain. For each key event it picks a voice: retrigger a matching voice, else a free voice, else steal one. It drives each voice's note registers, load strobe and envelope gate, and frees a voice when its envelope reports release complete.

## Interface
Parameters:
- `NUM_VOICES`, default 4: number of voice datapaths; 2..8.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `key_valid` in 1: key event present.
- `key_ready` out 1: allocator can accept an event.
- `key_on` in 1: 1 = press, 0 = release.
- `key_note` in 4: note index 0..11.
- `key_octave` in 3: octave 0..6.
- `voice_done` in NUM_VOICES: per-voice envelope reached zero after release.
- `voice_gate` out NUM_VOICES: per-voice `note_in` level to the envelope.
- `voice_load` out NUM_VOICES: one-cycle pulse; the voice latches note/octave and restarts its envelope.
- `voice_note` out 4*NUM_VOICES: registered note per voice; voice v occupies bits [4v+3:4v].
- `voice_octave` out 3*NUM_VOICES: registered octave per voice; voice v occupies bits [3v+2:3v].
- `drop_pulse` out 1: one-cycle pulse when a key-on is rejected.
- `active_count` out $clog2(NUM_VOICES+1): registered count of non-FREE voices.

## Operation
Per-voice state:
- FREE → HELD on an allocating key-on.
- HELD → RELEASING on a matching key-off; `voice_gate` falls.
- RELEASING → FREE on `voice_done`.
- RELEASING → HELD on retrigger or steal.
- `voice_done` is ignored unless the voice is RELEASING.

Request FSM, IDLE → SEARCH → APPLY → IDLE:
- `key_ready` = (state == IDLE).
- An event is captured on a clock edge where `key_valid && key_ready`.
- SEARCH registers the target voice and the action.

Key-on priority:
1. Match: a HELD or RELEASING voice with the same note and octave is retriggered.
2. Free: the lowest-index FREE voice is allocated.
3. Steal: the oldest RELEASING voice is taken; if none is RELEASING, the oldest HELD voice.
4. Drop: if nothing is available, the event is dropped.

Key-off rules:
- The HELD voice with matching note and octave → RELEASING.
- No match → no effect; `drop_pulse` is not raised.

Age ranks:
- Each voice has a rank 0..NUM_VOICES-1.
- On load, the loaded voice gets rank 0; every voice with a smaller rank increments.
- Oldest = maximum rank. Ties go to the lowest index.

APPLY:
- Writes the voice state, note, octave and rank.
- Raises `voice_load[v]`.
- `voice_gate[v]` stays high on a retrigger; the envelope restart is keyed off `voice_load`.

Reset values: all voices FREE, ranks = index, `voice_gate` 0, `voice_load` 0, `voice_note`/`voice_octave` 0, `drop_pulse` 0, `active_count` 0, FSM IDLE (`key_ready` 1).

## Timing
- Event accepted at edge E0; SEARCH after E0; APPLY after E1.
- At E2: voice registers update, `voice_load`/`drop_pulse` are high for the cycle E2–E3, and `key_ready` returns high.
- Throughput: one event per 3 cycles.
- `voice_gate` and `active_count` reflect the new state in the cycle after E2.
- `voice_done` in the APPLY cycle for the voice APPLY targets: APPLY wins and the done is lost.
- `voice_done` for a voice chosen in SEARCH: the voice frees, then APPLY still takes it.
- Reset asserted mid-SEARCH or mid-APPLY: the pending event is discarded, with no load or drop pulse.

## Configuration
- `VOICE_STEAL_EN` defined: priority step 3 (steal) is active.
- Undefined: key-on with no match and no FREE voice pulses `drop_pulse` and no voice changes.

## Structure
- Shared package `voice_pkg` holds:
  - voice state encoding FREE/HELD/RELEASING;
  - `NOTE_W`=4, `OCT_W`=3;
  - request FSM state encoding.
- Sub-module `voice_age_tracker`: rank registers, update on load, and oldest-voice select with a RELEASING-preferred mask.

## Test plan
- Reset: all outputs are at reset values, `key_ready`=1 and `active_count`=0.
- Four key-ons, notes 0..3, octave 4, back-to-back → `voice_load` bits 0..3 pulse 3 cycles apart, `voice_note`=3,2,1,0 (voices 3..0), `active_count`=4.
- Key-on note 2 octave 4 again → `voice_load[2]` only, gate stays 1, `active_count` stays 4.
- Fifth key-on, note 5 → with the macro, `voice_load[0]` and `voice_note[0]`=5; without it, `drop_pulse`=1 and no load.
- Key-off note 1 → `voice_gate[1]`=0. Then key-on note 7 (steal) → voice 1 is taken although voice 0 is older-HELD.
- `voice_done[3]` while HELD → ignored. Key-off note 3, then `voice_done[3]` → `active_count` drops by 1. Reset during SEARCH → no `voice_load`, all voices FREE.
